// File: rtl/alu_entry_sequencer.sv
// Front-panel sequencer: latches operand A, operand B and opcode from the switches on successive
// button presses, launches the ALU, waits for its result, and holds it for display.
// Optional long-press abort is enabled by defining ALU_SEQ_LONGPRESS_EN.
module alu_entry_sequencer #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned OPW         = 3,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned LONG_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic [WIDTH-1:0] sw,
   input  logic             alu_valid,
   input  logic [WIDTH:0]   alu_result,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [OPW-1:0]   opcode,
   output logic             alu_start,
   output logic [WIDTH:0]   result_q,
   output logic             result_valid,
   output logic             err,
   output logic [2:0]       state_o
);

   localparam int unsigned TMO   = (TIMEOUT < 1) ? 1 : TIMEOUT;
   localparam int unsigned CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      WAIT    = 3'd4,
      SHOW    = 3'd5
   } state_t;

   state_t           state_q, state_nx;
   logic             btn_d, armed, press, abort;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic [WIDTH-1:0] op_a_nx, op_b_nx;
   logic [OPW-1:0]   opcode_nx;
   logic             start_nx, valid_nx, err_nx;
   logic [WIDTH:0]   result_nx;

   // armed stays low until btn is seen low, so a button held through reset is not a press
   assign press = btn & ~btn_d & armed;

`ifdef ALU_SEQ_LONGPRESS_EN
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   logic [HOLD_W-1:0] hold_q;

   // Saturating hold counter; saturation makes the abort fire once per hold
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_q <= '0;
      end else if (!btn) begin
         hold_q <= '0;
      end else if (hold_q != HOLD_W'(LONG_CYCLES)) begin
         hold_q <= hold_q + HOLD_W'(1);
      end
   end

   assign abort = btn && (hold_q == HOLD_W'(LONG_CYCLES - 1)) && (state_q != WAIT);
`else
   localparam int unsigned unused_long_cycles = LONG_CYCLES;

   assign abort = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= LOAD_A;
         btn_d        <= 1'b0;
         armed        <= 1'b0;
         cnt_q        <= '0;
         op_a         <= '0;
         op_b         <= '0;
         opcode       <= '0;
         alu_start    <= 1'b0;
         result_q     <= '0;
         result_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_q      <= state_nx;
         btn_d        <= btn;
         armed        <= armed | ~btn;
         cnt_q        <= cnt_nx;
         op_a         <= op_a_nx;
         op_b         <= op_b_nx;
         opcode       <= opcode_nx;
         alu_start    <= start_nx;
         result_q     <= result_nx;
         result_valid <= valid_nx;
         err          <= err_nx;
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_nx  = state_q;
      cnt_nx    = cnt_q;
      op_a_nx   = op_a;
      op_b_nx   = op_b;
      opcode_nx = opcode;
      start_nx  = 1'b0;
      result_nx = result_q;
      valid_nx  = result_valid;
      err_nx    = err;

      case (state_q)
         LOAD_A: begin
            if (press) begin
               op_a_nx  = sw;
               state_nx = LOAD_B;
            end
         end
         LOAD_B: begin
            if (press) begin
               op_b_nx  = sw;
               state_nx = LOAD_OP;
            end
         end
         LOAD_OP: begin
            if (press) begin
               opcode_nx = sw[OPW-1:0];
               start_nx  = 1'b1;
               state_nx  = EXEC;
            end
         end
         EXEC: begin
            cnt_nx   = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            cnt_nx = cnt_q + CNT_W'(1);
            // A valid on the expiry cycle takes priority over the timeout
            if (alu_valid) begin
               result_nx = alu_result;
               valid_nx  = 1'b1;
               err_nx    = 1'b0;
               state_nx  = SHOW;
            end else if (cnt_q == CNT_W'(TMO - 1)) begin
               result_nx = '0;
               valid_nx  = 1'b0;
               err_nx    = 1'b1;
               state_nx  = SHOW;
            end
         end
         SHOW: begin
            if (press) begin
               valid_nx = 1'b0;
               err_nx   = 1'b0;
               state_nx = LOAD_A;
            end
         end
         default: state_nx = LOAD_A;
      endcase

      if (abort) begin
         state_nx  = LOAD_A;
         op_a_nx   = '0;
         op_b_nx   = '0;
         opcode_nx = '0;
         start_nx  = 1'b0;
         result_nx = '0;
         valid_nx  = 1'b0;
         err_nx    = 1'b0;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Scoreboard bench for alu_entry_sequencer: directed front-panel sequences push expected ALU
// launches and results; a monitor pops and compares them as the DUT presents them.
module tb_alu_entry_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic [3:0] sw;
   logic       alu_valid;
   logic [4:0] alu_result;
   logic [3:0] op_a, op_b;
   logic [2:0] opcode;
   logic       alu_start;
   logic [4:0] result_q;
   logic       result_valid, err;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
   } exec_t;

   typedef struct packed {
      logic [4:0] res;
      logic       rv;
      logic       er;
      logic [7:0] lat;
   } res_t;

   exec_t exec_q[$];
   res_t  res_q[$];

   alu_entry_sequencer #(
      .WIDTH(4), .OPW(3), .TIMEOUT(16), .LONG_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .sw(sw),
      .alu_valid(alu_valid), .alu_result(alu_result),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .alu_start(alu_start),
      .result_q(result_q), .result_valid(result_valid), .err(err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic press(input logic [3:0] v);
      @(negedge clk); sw = v; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
   endtask

   task automatic push(input exec_t e, input res_t r, input bit with_res);
      exec_q.push_back(e);
      if (with_res) res_q.push_back(r);
   endtask

   // Opcode press, then ALU answers on WAIT cycle d (d=0: never answers)
   task automatic launch(input logic [3:0] opsw, input int d, input logic [4:0] res);
      @(negedge clk); sw = opsw; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      chk("start_high", 32'(alu_start), 32'd1);
      @(negedge clk);
      chk("start_one_cycle", 32'(alu_start), 32'd0);
      if (d > 0) begin
         repeat (d - 1) @(negedge clk);
         alu_valid = 1'b1; alu_result = res;
         @(negedge clk); alu_valid = 1'b0;
      end else begin
         repeat (15) @(negedge clk);
         chk("wait_before_expiry", 32'({state_o, err}), 32'({3'd4, 1'b0}));
         @(negedge clk);
      end
      chk("state_show", 32'(state_o), 32'd5);
   endtask

   // Monitor: compares each ALU launch and each result presentation against the queues
   initial begin
      int    cyc;
      int    start_cyc;
      logic  [2:0] prev;
      exec_t e;
      res_t  r;
      cyc = 0; start_cyc = 0; prev = 3'd0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst === 1'b1 && alu_start === 1'b1) begin
            start_cyc = cyc;
            chk("exec_expected", 32'(exec_q.size() > 0), 32'd1);
            if (exec_q.size() > 0) begin
               e = exec_q.pop_front();
               chk("exec_operands", 32'({op_a, op_b, opcode}), 32'(e));
            end
         end
         if (rst === 1'b1 && state_o === 3'd5 && prev !== 3'd5) begin
            chk("result_expected", 32'(res_q.size() > 0), 32'd1);
            if (res_q.size() > 0) begin
               r = res_q.pop_front();
               chk("result_fields", 32'({result_q, result_valid, err}), 32'({r.res, r.rv, r.er}));
               chk("result_latency", 32'(cyc - start_cyc), 32'(r.lat));
            end
         end
         prev = state_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; btn = 1'b0; sw = 4'd0; alu_valid = 1'b0; alu_result = 5'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_ops", 32'({op_a, op_b, opcode}), 32'd0);
      chk("reset_outs", 32'({result_q, result_valid, err, alu_start}), 32'd0);

      // Basic operation: 3, 5, opcode 0, ALU answers 8 on WAIT cycle 2
      press(4'd3);
      chk("load_a", 32'({state_o, op_a}), 32'({3'd1, 4'd3}));
      press(4'd5);
      chk("load_b", 32'({state_o, op_b}), 32'({3'd2, 4'd5}));
      push('{4'd3, 4'd5, 3'd0}, '{5'd8, 1'b1, 1'b0, 8'd3}, 1'b1);
      launch(4'd0, 2, 5'd8);
      chk("basic_result", 32'({result_q, result_valid, err}), 32'({5'd8, 1'b1, 1'b0}));
      press(4'd0);
      chk("show_exit", 32'({state_o, result_valid, err}), 32'd0);
      chk("ops_kept", 32'({op_a, op_b}), 32'({4'd3, 4'd5}));

      // Timeout; opcode truncated from sw=0xE
      press(4'd1);
      press(4'd2);
      push('{4'd1, 4'd2, 3'd6}, '{5'd0, 1'b0, 1'b1, 8'd17}, 1'b1);
      launch(4'hE, 0, 5'd0);
      @(negedge clk); alu_valid = 1'b1; alu_result = 5'd5;
      @(negedge clk); alu_valid = 1'b0;
      chk("valid_ignored_in_show", 32'({state_o, result_q, result_valid, err}),
          32'({3'd5, 5'd0, 1'b0, 1'b1}));
      press(4'd0);
      chk("timeout_clear", 32'({state_o, err}), 32'd0);

      // Valid on the expiry cycle wins
      press(4'hF);
      press(4'hF);
      push('{4'hF, 4'hF, 3'd7}, '{5'h1F, 1'b1, 1'b0, 8'd17}, 1'b1);
      launch(4'hF, 16, 5'h1F);
      chk("collision", 32'({result_q, result_valid, err}), 32'({5'h1F, 1'b1, 1'b0}));
      press(4'd0);

      // Long hold in LOAD_A: single press only; sw changes mid-hold must not be captured
      @(negedge clk); sw = 4'd9; btn = 1'b1;
      @(negedge clk); sw = 4'd6;
      repeat (48) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
`ifdef ALU_SEQ_LONGPRESS_EN
      chk("hold_filter", 32'({state_o, op_a}), 32'({3'd0, 4'd0}));
      press(4'd9);
`else
      chk("hold_filter", 32'({state_o, op_a}), 32'({3'd1, 4'd9}));
`endif

      // Presses during EXEC/WAIT ignored
      press(4'd2);
      push('{4'd9, 4'd2, 3'd5}, '{5'h0B, 1'b1, 1'b0, 8'd5}, 1'b1);
      @(negedge clk); sw = 4'd5; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      chk("exec_entered", 32'(state_o), 32'd3);
      @(negedge clk); sw = 4'd3; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      @(negedge clk); btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      chk("wait_press_ignored", 32'({state_o, opcode}), 32'({3'd4, 3'd5}));
      alu_valid = 1'b1; alu_result = 5'h0B;
      @(negedge clk); alu_valid = 1'b0;
      chk("wait_press_show", 32'(state_o), 32'd5);
      press(4'd0);

      // Reset mid-WAIT, then a late alu_valid
      press(4'd1);
      press(4'd1);
      push('{4'd1, 4'd1, 3'd1}, '{5'd0, 1'b0, 1'b0, 8'd0}, 1'b0);
      @(negedge clk); sw = 4'd1; btn = 1'b1;
      @(negedge clk); btn = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_wait", 32'(state_o), 32'd4);
      rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      chk("midreset_state", 32'(state_o), 32'd0);
      chk("midreset_ops", 32'({op_a, op_b, opcode}), 32'd0);
      chk("midreset_outs", 32'({result_q, result_valid, err, alu_start}), 32'd0);
      alu_valid = 1'b1; alu_result = 5'd7;
      @(negedge clk); alu_valid = 1'b0;
      @(negedge clk);
      chk("late_valid_ignored", 32'({state_o, result_q, result_valid}), 32'd0);

      // Long hold of the opcode press
      press(4'd3);
      press(4'd5);
      push('{4'd3, 4'd5, 3'd6}, '{5'd0, 1'b0, 1'b1, 8'd17}, 1'b1);
      @(negedge clk); sw = 4'd6; btn = 1'b1;
      @(negedge clk);
      chk("long_exec", 32'(state_o), 32'd3);
      @(negedge clk);
      chk("long_wait", 32'(state_o), 32'd4);
      repeat (23) @(negedge clk);
      btn = 1'b0;
`ifdef ALU_SEQ_LONGPRESS_EN
      chk("long_abort", 32'({state_o, op_a, op_b, opcode, err}), 32'd0);
`else
      chk("long_no_abort", 32'({state_o, op_a, op_b, opcode, err}),
          32'({3'd5, 4'd3, 4'd5, 3'd6, 1'b1}));
      press(4'd0);
      chk("long_exit", 32'(state_o), 32'd0);
`endif

      repeat (2) @(negedge clk);
      chk("exec_queue_drained", 32'(exec_q.size()), 32'd0);
      chk("result_queue_drained", 32'(res_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
